// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit port bundle: hazard/execute controls in, fetch and decode PCs out.
// trap_o exists only when MISALIGN_TRAP_EN is defined.
interface pc_fetch_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic            stall_f;
   logic            stall_d;
   logic            flush_d;
   logic            redirect_e;
   logic            jalr_e;
   logic [XLEN-1:0] pc_e;
   logic [XLEN-1:0] imm_e;
   logic [XLEN-1:0] alu_e;
   logic [XLEN-1:0] pc_f;
   logic [XLEN-1:0] pc_plus4_f;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] pc_plus4_d;
   logic            valid_d;
`ifdef MISALIGN_TRAP_EN
   logic            trap_o;
`endif

   modport master (
`ifdef MISALIGN_TRAP_EN
      input  trap_o,
`endif
      output stall_f, stall_d, flush_d, redirect_e, jalr_e, pc_e, imm_e, alu_e,
      input  pc_f, pc_plus4_f, pc_d, pc_plus4_d, valid_d
   );

   modport slave (
`ifdef MISALIGN_TRAP_EN
      output trap_o,
`endif
      input  stall_f, stall_d, flush_d, redirect_e, jalr_e, pc_e, imm_e, alu_e,
      output pc_f, pc_plus4_f, pc_d, pc_plus4_d, valid_d
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter, redirect-target adder and fetch-to-decode register for the RV32I pipeline.
// Optional macro MISALIGN_TRAP_EN: redirects to a target with bit1 set go to TRAP_VEC and pulse trap_o.
module pc_fetch_unit #(
   parameter int unsigned     XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_VEC   = 32'hBFC00000,
   parameter logic [XLEN-1:0] JALR_OFFSET = 32'hBFC00000,
   parameter logic [XLEN-1:0] TRAP_VEC    = 32'hBFC00100
) (
   input logic             clk,
   input logic             rst,
   pc_fetch_unit_if.slave  bus
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_plus4;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] jalr_sum;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] pc_d_q;
   logic [XLEN-1:0] pc_plus4_d_q;
   logic            valid_d_q;
`ifdef MISALIGN_TRAP_EN
   logic            take_trap;
   logic            trap_q;
`endif

   assign pc_plus4 = pc_q + XLEN'(4);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      jalr_sum = bus.alu_e + JALR_OFFSET;
      target   = bus.jalr_e ? (jalr_sum & ~XLEN'(1)) : (bus.pc_e + bus.imm_e);
      pc_next  = pc_plus4;
`ifdef MISALIGN_TRAP_EN
      take_trap = bus.redirect_e & target[1];
      if (take_trap)           pc_next = TRAP_VEC;
      else if (bus.redirect_e) pc_next = target;
      else if (bus.stall_f)    pc_next = pc_q;
`else
      if (bus.redirect_e)      pc_next = target;
      else if (bus.stall_f)    pc_next = pc_q;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments so all registers sample the same pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) pc_q <= RESET_VEC;
      else     pc_q <= pc_next;
   end

   // A redirect squashes the wrong-path fetch on its own; flushed PCs are left stale.
   // NOTE: only valid_d needs clearing on a bubble, so the PC fields skip the extra mux.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_d_q       <= '0;
         pc_plus4_d_q <= '0;
         valid_d_q    <= 1'b0;
      end else if (bus.redirect_e || bus.flush_d) begin
         valid_d_q    <= 1'b0;
      end else if (!bus.stall_d) begin
         pc_d_q       <= pc_q;
         pc_plus4_d_q <= pc_plus4;
         valid_d_q    <= 1'b1;
      end
   end

`ifdef MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (rst) trap_q <= 1'b0;
      else     trap_q <= take_trap;
   end

   assign bus.trap_o = trap_q;
`endif

   assign bus.pc_f       = pc_q;
   assign bus.pc_plus4_f = pc_plus4;
   assign bus.pc_d       = pc_d_q;
   assign bus.pc_plus4_d = pc_plus4_d_q;
   assign bus.valid_d    = valid_d_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Parametrised program-counter and fetch-stage unit for the pipelined RV32I core; successor to the single-cycle PC register.
- Generates the fetch PC and computes branch/JAL/JALR redirect targets from execute-stage operands.
- Owns the fetch-to-decode pipeline register (PC, PC+4, valid) with stall and flush control driven by the hazard unit.

Parameters:
- XLEN, 32, datapath/PC width in bits.
- RESET_VEC, 32'hBFC00000, PC value loaded on reset (start of instruction memory).
- JALR_OFFSET, 32'hBFC00000, constant added to the ALU result for JALR targets (memory-map base).
- TRAP_VEC, 32'hBFC00100, PC loaded on a misaligned redirect (used only with MISALIGN_TRAP_EN).

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- stall_f  in  1  hold pc_f.
- stall_d  in  1  hold decode register.
- flush_d  in  1  insert bubble into decode register.
- redirect_e  in  1  execute-stage control transfer taken (branch taken, JAL or JALR).
- jalr_e  in  1  redirect is JALR (target from ALU).
- pc_e  in  XLEN  PC of the instruction in execute.
- imm_e  in  XLEN  sign-extended immediate of that instruction.
- alu_e  in  XLEN  ALU result (rs1+imm) for JALR.
- pc_f  out  XLEN  current fetch PC to instruction memory.
- pc_plus4_f  out  XLEN  pc_f+4, combinational.
- pc_d  out  XLEN  decode-stage PC.
- pc_plus4_d  out  XLEN  decode-stage PC+4 (link value).
- valid_d  out  1  decode-stage instruction is real (0 = bubble).
- trap_o  out  1  misaligned-target trap pulse (present only with MISALIGN_TRAP_EN).

Behaviour:
- Arithmetic modulo 2^XLEN; overflow wraps silently.
- Target: jalr_e=1 -> (alu_e + JALR_OFFSET) with bit0 cleared; else pc_e + imm_e.
- pc_f next-state priority: rst -> RESET_VEC; redirect_e -> target; stall_f -> hold; else pc_f+4.
- redirect_e overrides stall_f in the same cycle.
- Decode register priority: rst -> pc_d=0, pc_plus4_d=0, valid_d=0; redirect_e or flush_d -> valid_d=0, pc_d/pc_plus4_d don't-care; stall_d -> hold all; else load pc_f, pc_plus4_f, valid_d=1.
- redirect_e squashes the wrong-path instruction in fetch by itself; no separate flush_d is needed.
- Latency: redirect asserted in cycle N -> pc_f=target in N+1; target instruction reaches decode (valid_d=1) in N+2.
- Reset values: pc_f=RESET_VEC, pc_plus4_f=RESET_VEC+4, pc_d=0, pc_plus4_d=0, valid_d=0, trap_o=0.
- First cycle after reset release: valid_d=1 with pc_d=RESET_VEC, unless stall_d is asserted.
- Reset asserted mid-operation overrides redirect, stall and flush on the same edge.
- stall_f=1 with stall_d=0 is legal; the decode register reloads the held pc_f (duplicate fetch; hazard unit guarantees flush_d in this case).

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - trap_o port exists.
  - A redirect whose computed target has bit1=1 is not taken; pc_f loads TRAP_VEC instead.
  - trap_o=1 for exactly the following cycle; decode is squashed as for a normal redirect.
  - trap_o resets to 0.
- Undefined:
  - trap_o port is absent.
  - Target is loaded unchanged, including bit1; no trap.

Test Plan:
- Reset sequence: rst=1 for 2 cycles then 0 -> pc_f=BFC00000, valid_d=0 during reset; then pc_f=BFC00004, BFC00008; pc_d=BFC00000, BFC00004 one cycle behind with valid_d=1.
- Stall: at pc_f=BFC00008, stall_f=stall_d=1 for 2 cycles -> pc_f, pc_d, valid_d unchanged for 2 cycles; increments resume to BFC0000C on release.
- Branch: redirect_e=1, jalr_e=0, pc_e=BFC00004, imm_e=0x10 -> next pc_f=BFC00014, valid_d=0; following cycle pc_d=BFC00014, valid_d=1.
- JALR: redirect_e=1, jalr_e=1, alu_e=0x21 -> pc_f=BFC00020 (bit0 cleared); pc_plus4_d later =BFC00024.
- Simultaneous events: redirect_e=1 with stall_f=1 -> target loaded; rst=1 with redirect_e=1 -> pc_f=BFC00000.
- Wrap and trap: RESET_VEC=FFFFFFFC -> pc_f=00000000 after one increment; with MISALIGN_TRAP_EN, branch target BFC00006 -> pc_f=BFC00100 and trap_o high for 1 cycle; without the macro -> pc_f=BFC00006.
